mult_div_unit: RTL and testbench

- Parametrised multicycle multiply/divide unit for the MIPS-style multicycle core, owning the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, under a start/busy/done handshake driven by the control unit FSM.
- Also supports direct HI/LO writes (MTHI/MTLO).
- Flags divide-by-zero so the control unit can raise an exception.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_if.sv | 29 ++
 rtl/mdu_div_step.sv | 24 ++
 rtl/mult_div_unit.sv | 175 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/mdu_if.sv
// Control-unit side bundle of the multiply/divide unit: request, HI/LO writes, status and results.
interface mdu_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder is one bit wider than the divisor, so a borrow out of
  // the top bit of the difference means the divisor does not fit.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, sign fix-up in a final cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic                 isDiv_q, isDiv_d;
  logic                 negQ_q, negQ_d;
  logic                 negR_q, negR_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 divZero_q, divZero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 reqDiv;
  logic                 reqSigned;
  logic [WIDTH-1:0]     absA;
  logic [WIDTH-1:0]     absB;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH-1:0]     stepRem;
  logic                 stepQ;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;

  assign reqDiv    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign reqSigned = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign absA      = (reqSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign absB      = (reqSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The accumulator holds {partial product, remaining multiplier bits}; add the
  // multiplicand when the multiplier LSB is set, keeping the carry for the shift.
  always_comb begin
    mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  end

  mdu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i     (acc_q[WIDTH-1]),
    .divisor_i (opnd_q),
    .rem_o     (stepRem),
    .q_o       (stepQ)
  );

  // Magnitude results are negated here according to the signs latched at start.
  always_comb begin
    product   = negQ_q ? -acc_q : acc_q;
    quotient  = negQ_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remainder = negR_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register-update logic for the IDLE/MUL/DIV/FIX sequence.
  always_comb begin
    state_d   = state_q;
    isDiv_d   = isDiv_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (reqDiv && (bus.b == '0)) begin
            done_d    = 1'b1;
            divZero_d = 1'b1;
          end else begin
            isDiv_d   = reqDiv;
            negQ_d    = reqSigned & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negR_d    = reqSigned & bus.a[WIDTH-1];
            opnd_d    = absB;
            acc_d     = {{WIDTH{1'b0}}, absA};
            cnt_d     = CW'(WIDTH);
            divZero_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = reqDiv ? DIV : MUL;
          end
        end else begin
          if (bus.hi_we) begin
            hi_d = bus.wdata;
          end
          if (bus.lo_we) begin
            lo_d = bus.wdata;
          end
        end
      end
      MUL: begin
        acc_d = {mulSum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      DIV: begin
        acc_d = {stepRem, acc_q[WIDTH-2:0], stepQ};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (isDiv_q) begin
          hi_d = remainder;
          lo_d = quotient;
        end else begin
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation without touching HI/LO beyond clearing them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      isDiv_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      isDiv_q   <= isDiv_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = divZero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: cycle-level behavioural model plus directed and random operations.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   compareEn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   busyCnt;

  mdu_if #(.WIDTH(W)) bus();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: expected outputs and the result waiting to appear.
  int           remaining = 0;
  logic         expBusy = 1'b0;
  logic         expDone = 1'b0;
  logic         expDz = 1'b0;
  logic [W-1:0] expHi = '0;
  logic [W-1:0] expLo = '0;
  logic [W-1:0] pendHi = '0;
  logic [W-1:0] pendLo = '0;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural result {HI, LO} from plain integer arithmetic.
  function automatic logic [2*W-1:0] refResult(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [2*W-1:0]  r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    r  = '0;
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[W-1:0], sq[W-1:0]};
      end
      default: begin
        uq = ua / ub;
        ur = ua % ub;
        r  = {ur[W-1:0], uq[W-1:0]};
      end
    endcase
    return r;
  endfunction

  // Cycle model: an accepted operation occupies W+1 edges, then HI/LO update with a done pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining = 0;
      expBusy   = 1'b0;
      expDone   = 1'b0;
      expDz     = 1'b0;
      expHi     = '0;
      expLo     = '0;
    end else begin
      expDone = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          expHi   = pendHi;
          expLo   = pendLo;
          expBusy = 1'b0;
          expDone = 1'b1;
        end
      end else if (bus.start) begin
        if (bus.op[1] && bus.b == '0) begin
          expDone = 1'b1;
          expDz   = 1'b1;
        end else begin
          {pendHi, pendLo} = refResult(bus.op, bus.a, bus.b);
          remaining = W + 1;
          expBusy   = 1'b1;
          expDz     = 1'b0;
        end
      end else begin
        if (bus.hi_we) expHi = bus.wdata;
        if (bus.lo_we) expLo = bus.wdata;
      end
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("busy", 32'(bus.busy), 32'(expBusy));
      checkOutput("done", 32'(bus.done), 32'(expDone));
      checkOutput("div_zero", 32'(bus.div_zero), 32'(expDz));
      checkOutput("hi", bus.hi, expHi);
      checkOutput("lo", bus.lo, expLo);
    end
  end

  task automatic clearInputs();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  // Issue one operation at a falling edge and wait (bounded) for its done pulse.
  // noise: 0 quiet, 1 random inputs while busy, 2 fixed DIV-by-zero start plus MTHI pulse mid-run.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int noise, output int nBusy);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    clearInputs();
    nBusy = 0;
    if (!bus.done) begin
      for (int i = 0; i < 200 && !bus.done; i++) begin
        if (bus.busy) nBusy++;
        clearInputs();
        if (noise == 1) begin
          bus.start = 1'($urandom);
          bus.op    = 2'($urandom);
          bus.a     = $urandom;
          bus.b     = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
          bus.hi_we = 1'($urandom);
          bus.lo_we = 1'($urandom);
          bus.wdata = $urandom;
        end else if (noise == 2 && i == 4) begin
          bus.start = 1'b1;
          bus.op    = OP_DIV;
          bus.a     = 32'd9;
          bus.b     = 32'd0;
          bus.hi_we = 1'b1;
          bus.wdata = 32'h0000DEAD;
        end
        @(negedge clk);
      end
      clearInputs();
      if (!bus.done) checkOutput("done_timeout", 32'(bus.done), 32'd1);
    end
  endtask

  task automatic writeHiLo(input logic hiWe, input logic loWe, input logic [W-1:0] data);
    bus.start = 1'b0;
    bus.hi_we = hiWe;
    bus.lo_we = loWe;
    bus.wdata = data;
    @(negedge clk);
    clearInputs();
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compareEn = 1'b1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_dz", 32'(bus.div_zero), 32'd0);
    checkOutput("rst_hi", bus.hi, 32'd0);
    checkOutput("rst_lo", bus.lo, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed multiply");
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, busyCnt);
    checkOutput("multu_hi", bus.hi, 32'hFFFFFFFE);
    checkOutput("multu_lo", bus.lo, 32'h00000001);
    checkOutput("multu_busy_cycles", 32'(busyCnt), 32'd33);
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 0, busyCnt);
    checkOutput("mult_neg_hi", bus.hi, 32'hFFFFFFFF);
    checkOutput("mult_neg_lo", bus.lo, 32'hFFFFFFEB);
    applyStimulus(OP_MULT, 32'h80000000, 32'h80000000, 0, busyCnt);
    checkOutput("mult_min_hi", bus.hi, 32'h40000000);
    checkOutput("mult_min_lo", bus.lo, 32'h00000000);

    $display("[TB] directed divide");
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, busyCnt);
    checkOutput("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    checkOutput("div_neg_hi", bus.hi, 32'hFFFFFFFF);
    applyStimulus(OP_DIVU, 32'd7, 32'd2, 0, busyCnt);
    checkOutput("divu_lo", bus.lo, 32'd3);
    checkOutput("divu_hi", bus.hi, 32'd1);
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, busyCnt);
    checkOutput("div_ovf_lo", bus.lo, 32'h80000000);
    checkOutput("div_ovf_hi", bus.hi, 32'd0);

    $display("[TB] divide by zero");
    @(negedge clk);
    writeHiLo(1'b1, 1'b0, 32'h11);
    writeHiLo(1'b0, 1'b1, 32'h22);
    applyStimulus(OP_DIV, 32'd5, 32'd0, 0, busyCnt);
    checkOutput("dz_done", 32'(bus.done), 32'd1);
    checkOutput("dz_flag", 32'(bus.div_zero), 32'd1);
    checkOutput("dz_busy", 32'(bus.busy), 32'd0);
    checkOutput("dz_hi", bus.hi, 32'h11);
    checkOutput("dz_lo", bus.lo, 32'h22);
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 0, busyCnt);
    checkOutput("dz_cleared", 32'(bus.div_zero), 32'd0);

    $display("[TB] ignored requests while busy");
    applyStimulus(OP_MULTU, 32'd3, 32'd5, 2, busyCnt);
    checkOutput("busy_ign_hi", bus.hi, 32'd0);
    checkOutput("busy_ign_lo", bus.lo, 32'd15);
    checkOutput("busy_ign_dz", 32'(bus.div_zero), 32'd0);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    writeHiLo(1'b1, 1'b0, 32'h77);
    bus.op    = OP_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_hi", bus.hi, 32'd0);
    checkOutput("abort_lo", bus.lo, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 0, busyCnt);
    checkOutput("after_rst_lo", bus.lo, 32'd14);
    checkOutput("after_rst_hi", bus.hi, 32'd2);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'd0;
        3: rb = 32'(10'($urandom));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        writeHiLo(1'($urandom), 1'($urandom), $urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
      end
      applyStimulus(rop, ra, rb, int'($urandom_range(0, 1)), busyCnt);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
